// File: rtl/fir_pkg.sv
// Shared constants and state type for the FIR result serializer.
// Defaults describe a Q15 FIR with a 38-bit accumulator and 16-bit samples.
package fir_pkg;

  localparam int unsigned BYTE_WIDTH           = 8;
  localparam int unsigned OUTPUT_WIDTH_DEFAULT = 38;
  localparam int unsigned SHIFT_DEFAULT        = 15;
  localparam int unsigned SAMPLE_WIDTH_DEFAULT = 16;

  typedef enum logic {
    Idle,
    Send
  } state_e;

  function automatic int unsigned num_bytes(int unsigned width);
    return (width + BYTE_WIDTH - 1) / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/fir_result_serializer_if.sv
// Result-capture and byte-stream signals between the FIR datapath, the serializer
// and the UART transmitter.
interface fir_result_serializer_if
  import fir_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEFAULT
);

  logic                    result_valid;
  logic [OUTPUT_WIDTH-1:0] result;
  logic                    result_ready;
  logic                    tx_valid;
  logic [BYTE_WIDTH-1:0]   tx_data;
  logic                    tx_ready;
  logic                    sat_flag;
  logic                    overrun;

  // Producer of results and consumer of bytes.
  modport master (
    output result_valid,
    output result,
    input  result_ready,
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    input  sat_flag,
    input  overrun
  );

  // The serializer itself.
  modport slave (
    input  result_valid,
    input  result,
    output result_ready,
    output tx_valid,
    output tx_data,
    input  tx_ready,
    output sat_flag,
    output overrun
  );

endinterface

// File: rtl/fir_round_saturate.sv
// Rounds a signed FIR accumulator by SHIFT bits (round half up) and clamps the
// result to a signed SAMPLE_WIDTH sample, flagging when clamping occurred.
module fir_round_saturate
  import fir_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEFAULT,
  parameter int unsigned SHIFT        = SHIFT_DEFAULT,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT
) (
  input  logic signed [OUTPUT_WIDTH-1:0] result,
  output logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic                           sat
);

  // One extra bit so adding the rounding half can never overflow.
  localparam int unsigned SumWidth = OUTPUT_WIDTH + 1;

  localparam logic signed [SumWidth-1:0] Half   = SumWidth'(1) << (SHIFT - 1);
  localparam logic signed [SumWidth-1:0] MaxVal =
    {{(SumWidth - SAMPLE_WIDTH + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
  localparam logic signed [SumWidth-1:0] MinVal =
    {{(SumWidth - SAMPLE_WIDTH + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

  logic signed [SumWidth-1:0] sum;
  logic signed [SumWidth-1:0] rounded;

  always_comb begin
    sum     = SumWidth'(result) + Half;
    rounded = sum >>> SHIFT;
    sample  = rounded[SAMPLE_WIDTH-1:0];
    sat     = 1'b0;
    if (rounded > MaxVal) begin
      sample = MaxVal[SAMPLE_WIDTH-1:0];
      sat    = 1'b1;
    end else if (rounded < MinVal) begin
      sample = MinVal[SAMPLE_WIDTH-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fir_result_serializer.sv
// Captures a finished FIR result and streams it LSB-first as bytes to a UART.
// Define FIR_SATURATE_EN to send a rounded, clamped sample instead of the full word.
module fir_result_serializer
  import fir_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEFAULT,
  parameter int unsigned SHIFT        = SHIFT_DEFAULT,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  fir_result_serializer_if.slave  bus
);

  if (SHIFT < 1 || SHIFT >= OUTPUT_WIDTH || SAMPLE_WIDTH < 2 || SAMPLE_WIDTH > OUTPUT_WIDTH)
  begin : g_bad_cfg
    $error("fir_result_serializer: unsupported SHIFT/SAMPLE_WIDTH for OUTPUT_WIDTH");
  end

`ifdef FIR_SATURATE_EN
  localparam int unsigned DataWidth = SAMPLE_WIDTH;
`else
  localparam int unsigned DataWidth = OUTPUT_WIDTH;
`endif
  localparam int unsigned NumBytes  = num_bytes(DataWidth);
  localparam int unsigned WordWidth = NumBytes * BYTE_WIDTH;
  localparam int unsigned IdxWidth  = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBytes - 1);

  state_e                state_q, state_d;
  logic [WordWidth-1:0]  word_q, word_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic                  overrun_q, overrun_d;
  logic [WordWidth-1:0]  load_word;
  logic                  sat;
  logic                  capture;

`ifdef FIR_SATURATE_EN
  logic signed [SAMPLE_WIDTH-1:0] sample;

  fir_round_saturate #(
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .SHIFT        (SHIFT),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_round_saturate (
    .result (bus.result),
    .sample (sample),
    .sat    (sat)
  );

  assign load_word = WordWidth'(sample);
`else
  assign load_word = WordWidth'($signed(bus.result));
  assign sat       = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    word_d           = word_q;
    idx_d            = idx_q;
    overrun_d        = overrun_q;
    capture          = 1'b0;
    bus.result_ready = (state_q == Idle);
    bus.tx_valid     = (state_q == Send);
    bus.tx_data      = word_q[BYTE_WIDTH-1:0];

    unique case (state_q)
      Idle: begin
        if (bus.result_valid) begin
          capture = 1'b1;
          word_d  = load_word;
          idx_d   = '0;
          state_d = Send;
        end
      end
      Send: begin
        // A result arriving now is dropped; only the sticky flag records it.
        if (bus.result_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.tx_ready) begin
          word_d = word_q >> BYTE_WIDTH;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = Idle;
          end
        end
      end
      default: state_d = Idle;
    endcase

    // A result presented during reset is never captured, so it cannot flag.
    bus.sat_flag = capture & sat & reset;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= Idle;
      word_q    <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun = overrun_q;

endmodule

// File: doc/fir_result_serializer.md
FIR_RESULT_SERIALIZER -- requirements
Module: fir_result_serializer

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 38, width of the signed FIR accumulator result.
REQ-002 Parameter SHIFT, default 15, arithmetic right shift applied in saturate mode (Q15 coefficients).
REQ-003 Parameter SAMPLE_WIDTH, default 16, signed width of the saturated sample.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  reset; synchronous and active-low.
REQ-006 result_valid  in  1  one-cycle strobe: result holds a finished FIR output.
REQ-007 result  in  OUTPUT_WIDTH  signed FIR output, sampled only when result_valid=1 and result_ready=1.
REQ-008 result_ready  out  1  high when idle and able to capture a result.
REQ-009 tx_valid  out  1  byte offered to UART transmitter.
REQ-010 tx_data  out  8  byte payload.
REQ-011 tx_ready  in  1  UART transmitter accepts tx_data this cycle.
REQ-012 sat_flag  out  1  one-cycle pulse on capture of a result that saturated (saturate mode only, else 0).
REQ-013 overrun  out  1  sticky: a result_valid arrived while result_ready=0.

Function
REQ-014 Two-state FSM, IDLE and SEND.
REQ-015 IDLE: result_ready=1 and tx_valid=0; on result_valid, load the processed word into the shift register, clear byte index, go to SEND.
REQ-016 Capture-to-first-byte latency is one cycle: result_valid in cycle k gives tx_valid=1 in cycle k+1.
REQ-017 SEND: tx_valid=1 and tx_data = shift register bits [7:0].
REQ-018 A byte transfers when tx_valid and tx_ready are both high; the register then shifts right 8 and the index increments.
REQ-019 tx_data and tx_valid are held stable while tx_ready=0.
REQ-020 Bytes are sent LSB first; NUM_BYTES = ceil(width/8).
REQ-021 On transfer of the last byte (index = NUM_BYTES-1), the FSM returns to IDLE.
REQ-022 result_ready=0 in every SEND cycle, including the last-byte cycle; the minimum capture spacing is NUM_BYTES+1 cycles.
REQ-023 result_valid while result_ready=0 sets overrun, discards the result and does not disturb the byte stream.
REQ-024 Full mode: the word is result sign-extended to 8*ceil(OUTPUT_WIDTH/8) bits (40 by default, 5 bytes).
REQ-025 Saturate mode, step 1: r = (result + 2^(SHIFT-1)) >>> SHIFT, computed in OUTPUT_WIDTH+1 bits (round half up).
REQ-026 Saturate mode, step 2: clamp r to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1], giving 2 bytes by default; sat_flag pulses in the capture cycle when clamping occurred.

Reset
REQ-027 reset=0 at a rising edge forces IDLE, tx_valid=0, tx_data=0, result_ready=1 the following cycle, and clears sat_flag, overrun, byte index and shift register.
REQ-028 Reset mid-SEND aborts the word, with no further bytes sent.
REQ-029 result_valid coincident with reset is ignored.

Configuration
REQ-030 Macro FIR_SATURATE_EN defined: saturate mode per REQ-025/026.
REQ-031 Macro FIR_SATURATE_EN undefined: full mode per REQ-024, and the rounding/saturation logic is not built (sat_flag tied 0).

Structure
REQ-032 Shared package fir_pkg holds BYTE_WIDTH=8, the state enum (IDLE, SEND) and the default OUTPUT_WIDTH, SHIFT and SAMPLE_WIDTH constants.
REQ-033 Rounding and clamping go in combinational sub-module fir_round_saturate (in: OUTPUT_WIDTH signed; out: SAMPLE_WIDTH signed, sat), instantiated only under FIR_SATURATE_EN.

Verification
REQ-034 Full mode, tx_ready=1: result=38'h12_3456_789A -> bytes 9A,78,56,34,12 on consecutive cycles; then result=-1 -> FF x5.
REQ-035 Saturate mode, rounding: result=32767*2^15 -> FF,7F; result=2^14 -> 01,00 (rounds up); result=2^14-1 -> 00,00.
REQ-036 Saturate mode, clamping: result=40000*2^15 -> FF,7F with sat_flag pulse; result=-40000*2^15 -> 00,80 with sat_flag pulse.
REQ-037 Back-pressure: tx_ready low 10 cycles during byte 1 -> tx_valid=1 and tx_data constant throughout; the stream resumes unchanged.
REQ-038 Overrun: second result_valid during SEND -> overrun=1 stays set, first word's bytes unchanged, second word never sent.
REQ-039 Reset: reset=0 for one cycle after byte 2 of 5 -> next cycle tx_valid=0, result_ready=1, overrun=0; a fresh word then sends all 5 bytes.
